// File: rtl/time_set_ctrl.sv
// Edit-mode sequencer for the watch counters: set button walks HR -> MIN -> SEC -> RUN,
// inc button issues increment pulses with hold-to-repeat, idle timeout returns to RUN.
module time_set_ctrl #(
    parameter int HOLD_CYC    = 500,
    parameter int REPEAT_CYC  = 100,
    parameter int TIMEOUT_CYC = 10000,
    parameter int BLINK_CYC   = 250,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_btn,
    input  logic       inc_btn,
    output logic       mode,
    output logic [1:0] sel,
    output logic       change_second,
    output logic       change_minute,
    output logic       change_hour,
    output logic       blink
);

    // State encoding equals the sel code, so sel is just the next state.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_SEC = 2'b01,
        SET_MIN = 2'b10,
        SET_HR  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

    state_t           r_state, w_next;
    logic             r_inc_prev, r_arm, w_arm_nx;
    logic [CNT_W-1:0] r_hold, w_hold_nx;
    logic [CNT_W-1:0] r_rep, w_rep_nx;
    logic [CNT_W-1:0] r_idle, w_idle_nx;
    logic [CNT_W-1:0] r_bcnt, w_bcnt_nx;
    logic             r_blink, w_blink_nx;
    logic             r_mode;
    logic [1:0]       r_sel;
    logic             r_chg_sec, r_chg_min, r_chg_hr;
    logic             w_pulse, w_rise;

    assign w_rise = inc_btn & ~r_inc_prev;

    always_comb begin
        w_next    = r_state;
        w_pulse   = 1'b0;
        w_arm_nx  = r_arm;
        w_hold_nx = r_hold;
        w_rep_nx  = r_rep;
        w_idle_nx = '0;
        if (r_state == RUN) begin
            w_arm_nx  = 1'b0;
            w_hold_nx = '0;
            w_rep_nx  = '0;
            if (set_btn) w_next = SET_HR;
        end else if (set_btn) begin
            // set_btn beats any inc activity in the same cycle
            w_arm_nx  = 1'b0;
            w_hold_nx = '0;
            w_rep_nx  = '0;
            case (r_state)
                SET_HR:  w_next = SET_MIN;
                SET_MIN: w_next = SET_SEC;
                default: w_next = RUN;
            endcase
        end else if (inc_btn) begin
            if (w_rise) begin
                w_pulse   = 1'b1;
                w_arm_nx  = 1'b1;
                w_hold_nx = '0;
                w_rep_nx  = '0;
            end else if (r_arm) begin
                // hold phase saturates at HOLD_SAT, then the repeat counter takes over
                if (r_hold != HOLD_SAT) begin
                    w_pulse   = (r_hold == HOLD_LAST);
                    w_hold_nx = r_hold + ONE;
                end else if (r_rep == REP_LAST) begin
                    w_pulse  = 1'b1;
                    w_rep_nx = '0;
                end else begin
                    w_rep_nx = r_rep + ONE;
                end
            end
        end else begin
            w_arm_nx  = 1'b0;
            w_hold_nx = '0;
            w_rep_nx  = '0;
            if (r_idle == TMO_LAST) w_next = RUN;
            else                    w_idle_nx = r_idle + ONE;
        end
    end

    always_comb begin
        w_bcnt_nx  = '0;
        w_blink_nx = 1'b0;
        if (w_next != RUN && w_next == r_state && !inc_btn) begin
            if (r_bcnt == BLINK_LAST) begin
                w_blink_nx = ~r_blink;
            end else begin
                w_bcnt_nx  = r_bcnt + ONE;
                w_blink_nx = r_blink;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_inc_prev <= 1'b0;
            r_arm      <= 1'b0;
            r_hold     <= '0;
            r_rep      <= '0;
            r_idle     <= '0;
            r_bcnt     <= '0;
            r_blink    <= 1'b0;
            r_mode     <= 1'b1;
            r_sel      <= 2'b00;
            r_chg_sec  <= 1'b0;
            r_chg_min  <= 1'b0;
            r_chg_hr   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inc_prev <= inc_btn;
            r_arm      <= w_arm_nx;
            r_hold     <= w_hold_nx;
            r_rep      <= w_rep_nx;
            r_idle     <= w_idle_nx;
            r_bcnt     <= w_bcnt_nx;
            r_blink    <= w_blink_nx;
            r_mode     <= (w_next == RUN);
            r_sel      <= w_next;
            r_chg_sec  <= w_pulse && (r_state == SET_SEC);
            r_chg_min  <= w_pulse && (r_state == SET_MIN);
            r_chg_hr   <= w_pulse && (r_state == SET_HR);
        end
    end

    assign mode          = r_mode;
    assign sel           = r_sel;
    assign change_second = r_chg_sec;
    assign change_minute = r_chg_min;
    assign change_hour   = r_chg_hr;
    assign blink         = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button activity, every cycle
// compared against a behavioural model of the field-select / increment / blink rules.
module tb_time_set_ctrl;
    localparam int HOLD = 500, REP = 100, TMO = 10000, BLK = 250;

    logic       clk = 1'b0, rst = 1'b0, set_btn = 1'b0, inc_btn = 1'b0;
    logic       mode, change_second, change_minute, change_hour, blink;
    logic [1:0] sel;

    always #5 clk = ~clk;

    time_set_ctrl #(.HOLD_CYC(HOLD), .REPEAT_CYC(REP), .TIMEOUT_CYC(TMO),
                    .BLINK_CYC(BLK), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .inc_btn(inc_btn),
        .mode(mode), .sel(sel), .change_second(change_second),
        .change_minute(change_minute), .change_hour(change_hour), .blink(blink));

    int tests = 0, fails = 0;
    // model: field 0 = watch, 1 = hour, 2 = minute, 3 = second
    int m_st, m_j, m_idle, m_n, m_pfield;
    bit m_prev, m_arm, m_pulse;
    int n_hr, n_min, n_sec;

    task automatic check(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_j = 0; m_idle = 0; m_n = 0; m_prev = 0; m_arm = 0; m_pulse = 0; m_pfield = 0;
    endtask

    task automatic model_edge(bit s, bit i);
        int old;
        old = m_st;
        m_pulse = 0;
        m_pfield = old;
        if (old == 0) begin
            if (s) m_st = 1;
            m_arm = 0; m_idle = 0;
        end else if (s) begin
            m_st = (old == 3) ? 0 : old + 1;
            m_arm = 0; m_idle = 0;
        end else if (i) begin
            m_idle = 0;
            if (!m_prev) begin
                m_arm = 1; m_j = 0; m_pulse = 1;
            end else if (m_arm) begin
                m_j++;
                m_pulse = (m_j >= HOLD) && ((m_j - HOLD) % REP == 0);
            end
        end else begin
            m_arm = 0;
            m_idle++;
            if (m_idle >= TMO) begin m_st = 0; m_idle = 0; end
        end
        if (m_st == 0 || m_st != old || i) m_n = 0;
        else m_n++;
        m_prev = i;
    endtask

    function automatic int exp_vec();
        int v;
        v = (m_st == 0) ? 64 : 0;
        v += ((m_st == 0) ? 0 : 4 - m_st) << 4;
        if (m_pulse && m_pfield == 3) v += 8;
        if (m_pulse && m_pfield == 2) v += 4;
        if (m_pulse && m_pfield == 1) v += 2;
        if (m_st != 0 && ((m_n / BLK) % 2 == 1)) v += 1;
        return v;
    endfunction

    function automatic int obs_vec();
        return int'({mode, sel, change_second, change_minute, change_hour, blink});
    endfunction

    task automatic tick(bit s, bit i);
        set_btn = s;
        inc_btn = i;
        @(posedge clk);
        model_edge(s, i);
        #1;
        check("cycle", obs_vec(), exp_vec());
        n_hr  += int'(change_hour);
        n_min += int'(change_minute);
        n_sec += int'(change_second);
        set_btn = 0;
    endtask

    task automatic clr_counts();
        n_hr = 0; n_min = 0; n_sec = 0;
    endtask

    initial begin
        int sel_tab[4]  = '{3, 2, 1, 0};
        int mode_tab[4] = '{0, 0, 0, 1};
        int pidx[$];
        int len, act;
        bit s;

        model_reset();
        clr_counts();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs_vec(), 64);
        rst = 1;

        // four set presses, 10 cycles apart
        for (int k = 0; k < 4; k++) begin
            tick(1, 0);
            check("set_sel", int'(sel), sel_tab[k]);
            check("set_mode", int'(mode), mode_tab[k]);
            repeat (9) tick(0, 0);
        end

        // SET_MIN, inc high for 3 cycles -> one minute pulse right after the rise
        tick(1, 0); tick(1, 0);
        clr_counts();
        tick(0, 1);
        check("min_rise_pulse", int'(change_minute), 1);
        tick(0, 1); tick(0, 1);
        repeat (3) tick(0, 0);
        check("min_pulse_count", n_min + n_hr + n_sec, 1);

        // asynchronous reset in SET_MIN while inc held
        tick(0, 1);
        #2 rst = 0;
        model_reset();
        #1;
        check("reset_mid_edit", obs_vec(), 64);
        #2 rst = 1;
        tick(0, 1); tick(0, 1); tick(0, 0);
        check("run_ignores_inc", int'(change_minute | change_hour | change_second), 0);

        // SET_HR, inc held 800 cycles -> pulses at rise, +500, +600, +700
        tick(1, 0);
        clr_counts();
        for (int k = 0; k < 800; k++) begin
            tick(0, 1);
            if (change_hour) pidx.push_back(k);
        end
        tick(0, 0);
        check("hold_count", n_hr, 4);
        check("hold_other", n_min + n_sec, 0);
        if (pidx.size() == 4) begin
            check("hold_p0", pidx[0], 0);
            check("hold_p1", pidx[1], 500);
            check("hold_p2", pidx[2], 600);
            check("hold_p3", pidx[3], 700);
        end else begin
            check("hold_pulse_list", pidx.size(), 4);
        end

        // simultaneous set and inc rise in SET_HR -> SET_MIN, no pulse; held inc stays silent
        clr_counts();
        tick(1, 1);
        check("simul_sel", int'(sel), 2);
        repeat (5) tick(0, 1);
        tick(0, 0);
        check("simul_no_pulse", n_hr + n_min + n_sec, 0);

        // SET_SEC idle timeout, with blink toggling after BLK idle cycles
        tick(1, 0);
        clr_counts();
        for (int k = 1; k <= TMO; k++) begin
            tick(0, 0);
            if (k == BLK - 1) check("blink_low", int'(blink), 0);
            if (k == BLK)     check("blink_high", int'(blink), 1);
            if (k == TMO - 1) check("tmo_pre_sel", int'(sel), 1);
        end
        check("tmo_mode", int'(mode), 1);
        check("tmo_sel", int'(sel), 0);
        check("tmo_no_pulse", n_hr + n_min + n_sec, 0);

        // random activity
        for (int seg = 0; seg < 70; seg++) begin
            act = $urandom_range(0, 9);
            if (act < 3) begin
                tick(1, ($urandom_range(0, 3) == 0));
            end else if (act < 7) begin
                len = $urandom_range(1, 760);
                for (int k = 0; k < len; k++) begin
                    s = ($urandom_range(0, 299) == 0);
                    tick(s, 1);
                end
            end else begin
                len = $urandom_range(1, 400);
                for (int k = 0; k < len; k++) tick(0, 0);
            end
            if (seg == 40) begin
                #2 rst = 0;
                model_reset();
                #1;
                check("reset_random", obs_vec(), 64);
                #2 rst = 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
